branch_wb_arbiter: RTL and testbench

BRANCH_WB_ARBITER -- requirements
Module: branch_wb_arbiter

---
 rtl/branch_wb_arbiter_pkg.sv | 34 +++
 rtl/branch_wb_fifo.sv | 79 +++++++
 rtl/branch_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_branch_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_wb_arbiter_pkg.sv
// Shared core types for branch writeback: ROB index with wrap bit, writeback
// payload, default sizing and the ROB age comparison.
package branch_wb_arbiter_pkg;

    localparam int ROB_IDX_W      = 5;
    localparam int FTQ_IDX_W      = 4;
    localparam int PC_W           = 32;
    localparam int DEFAULT_NUM_IN = 2;
    localparam int DEFAULT_DEPTH  = 4;

    typedef struct packed {
        logic                 flip;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        robIdx_t              rob_idx;
        logic [FTQ_IDX_W-1:0] ftq_idx;
        logic                 has_mispred;
        logic                 branch_taken;
        logic [PC_W-1:0]      target_pc;
        logic [PC_W-1:0]      branch_npc;
    } branchwbInfo_t;

    // True when a is strictly older than b. Equal flip bits: lower index is
    // older. Different flip bits: b has wrapped past a, so higher index is older.
    function automatic logic is_older(input robIdx_t a, input robIdx_t b);
        if (a.flip == b.flip) begin
            return a.idx < b.idx;
        end
        return a.idx > b.idx;
    endfunction

endpackage

// File: rtl/branch_wb_fifo.sv
// Branch writeback queue: payload storage, per-entry kill bits and wrap-bit
// pointers. Up to NUM_IN pre-sorted slots are written per cycle; one entry
// leaves per cycle.
module branch_wb_fifo
    import branch_wb_arbiter_pkg::*;
#(
    parameter int  DEPTH  = DEFAULT_DEPTH,
    parameter int  NUM_IN = DEFAULT_NUM_IN,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PW-1:0]              enq_cnt,
    input  branchwbInfo_t [NUM_IN-1:0] slot_data,
    input  logic [NUM_IN-1:0]          slot_kill,
    input  logic                       deq,
    input  logic                       squash_vld,
    input  robIdx_t                    squash_idx,
    output branchwbInfo_t              head_data,
    output logic                       head_kill,
    output logic                       empty,
    output logic [PW-1:0]              count
);

    branchwbInfo_t   mem [DEPTH];
    logic [DEPTH-1:0] kill;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_addr [NUM_IN];
    logic [NUM_IN-1:0] slot_en;

    // Consecutive write addresses for the sorted slots, wrapping modulo DEPTH
    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            wr_addr[k] = wr_ptr[AW-1:0] + AW'(k);
            slot_en[k] = int'(enq_cnt) > k;
        end
    end

    // Pointers and kill bits; a squash marks younger entries, new writes set their own kill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            kill   <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (squash_vld && is_older(squash_idx, mem[e].rob_idx)) begin
                    kill[e] <= 1'b1;
                end
            end
            for (int k = 0; k < NUM_IN; k++) begin
                if (slot_en[k]) begin
                    kill[wr_addr[k]] <= slot_kill[k];
                end
            end
            wr_ptr <= wr_ptr + enq_cnt;
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Payload storage, no reset needed
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (slot_en[k]) begin
                mem[wr_addr[k]] <= slot_data[k];
            end
        end
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign head_kill = kill[rd_ptr[AW-1:0]];
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);

endmodule

// File: rtl/branch_wb_arbiter.sv
// Branch writeback arbiter: collects ALU/BRU branch results, orders them by
// ROB age into a queue toward the FTQ, and sends the oldest mispredict of each
// accepted group straight out as a one-cycle redirect.
module branch_wb_arbiter
    import branch_wb_arbiter_pkg::*;
#(
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IN-1:0]          i_branchwb_vld,
    input  branchwbInfo_t [NUM_IN-1:0] i_branchwbInfo,
    output logic                       o_wb_stall,
    input  logic                       i_squash_vld,
    input  robIdx_t                    i_squash_robIdx,
    output logic                       o_ftq_vld,
    output branchwbInfo_t              o_ftq_info,
    input  logic                       i_ftq_ready,
    output logic                       o_mispred_vld,
    output branchwbInfo_t              o_mispred_info
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [NUM_IN-1:0]          accept;
    int                         rank [NUM_IN];
    logic [PW-1:0]              enq_cnt;
    branchwbInfo_t [NUM_IN-1:0] slot_data;
    logic [NUM_IN-1:0]          slot_kill;
    branchwbInfo_t              head_data;
    logic                       head_kill;
    logic                       empty;
    logic                       deq;
    logic [PW-1:0]              count;
    logic [PW-1:0]              count_next;
    logic                       mp_found;
    branchwbInfo_t              mp_info;
    logic                       mp_squashed;

    assign accept = o_wb_stall ? '0 : i_branchwb_vld;

    // Age rank of each accepted input; equal ages fall back to source order
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            rank[i] = 0;
            for (int j = 0; j < NUM_IN; j++) begin
                if (j != i && accept[j] &&
                    (is_older(i_branchwbInfo[j].rob_idx, i_branchwbInfo[i].rob_idx) ||
                     (j < i && !is_older(i_branchwbInfo[i].rob_idx, i_branchwbInfo[j].rob_idx)))) begin
                    rank[i] = rank[i] + 1;
                end
            end
        end
    end

    // Place accepted inputs into oldest-first slots with their same-cycle kill
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (accept[i]) begin
                enq_cnt = enq_cnt + PW'(1);
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            slot_data[k] = '0;
            slot_kill[k] = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (accept[i] && rank[i] == k) begin
                    slot_data[k] = i_branchwbInfo[i];
                    slot_kill[k] = i_squash_vld &&
                                   is_older(i_squash_robIdx, i_branchwbInfo[i].rob_idx);
                end
            end
        end
    end

    // Oldest accepted mispredict this cycle, bypassing the queue
    always_comb begin
        mp_found = 1'b0;
        mp_info  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (accept[i] && i_branchwbInfo[i].has_mispred &&
                (!mp_found || is_older(i_branchwbInfo[i].rob_idx, mp_info.rob_idx))) begin
                mp_found = 1'b1;
                mp_info  = i_branchwbInfo[i];
            end
        end
        mp_squashed = i_squash_vld && is_older(i_squash_robIdx, mp_info.rob_idx);
    end

    branch_wb_fifo #(
        .DEPTH  (DEPTH),
        .NUM_IN (NUM_IN)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .enq_cnt    (enq_cnt),
        .slot_data  (slot_data),
        .slot_kill  (slot_kill),
        .deq        (deq),
        .squash_vld (i_squash_vld),
        .squash_idx (i_squash_robIdx),
        .head_data  (head_data),
        .head_kill  (head_kill),
        .empty      (empty),
        .count      (count)
    );

    // Killed heads drain one per cycle without a valid; live heads wait for ready
    assign deq        = !empty && (head_kill || i_ftq_ready);
    assign o_ftq_vld  = !empty && !head_kill;
    assign o_ftq_info = head_data;
    assign count_next = count + enq_cnt - PW'(deq);

    // Stall once the next cycle could not absorb a full wave; one-cycle redirect pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wb_stall    <= 1'b0;
            o_mispred_vld <= 1'b0;
        end else begin
            o_wb_stall    <= int'(count_next) > (DEPTH - NUM_IN);
            o_mispred_vld <= mp_found && !mp_squashed;
        end
    end

    // Redirect payload, no reset needed
    always_ff @(posedge clk) begin
        if (mp_found) begin
            o_mispred_info <= mp_info;
        end
    end

endmodule

// File: tb/tb_branch_wb_arbiter.sv
// Self-checking bench for branch_wb_arbiter: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_wb_arbiter;
    import branch_wb_arbiter_pkg::*;

    localparam int NUM_IN = 2;
    localparam int DEPTH  = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_IN-1:0]          i_branchwb_vld;
    branchwbInfo_t [NUM_IN-1:0] i_branchwbInfo;
    logic                       o_wb_stall;
    logic                       i_squash_vld;
    robIdx_t                    i_squash_robIdx;
    logic                       o_ftq_vld;
    branchwbInfo_t              o_ftq_info;
    logic                       i_ftq_ready;
    logic                       o_mispred_vld;
    branchwbInfo_t              o_mispred_info;

    branch_wb_arbiter #(.NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_branchwb_vld  (i_branchwb_vld),
        .i_branchwbInfo  (i_branchwbInfo),
        .o_wb_stall      (o_wb_stall),
        .i_squash_vld    (i_squash_vld),
        .i_squash_robIdx (i_squash_robIdx),
        .o_ftq_vld       (o_ftq_vld),
        .o_ftq_info      (o_ftq_info),
        .i_ftq_ready     (i_ftq_ready),
        .o_mispred_vld   (o_mispred_vld),
        .o_mispred_info  (o_mispred_info)
    );

    always #5 clk = ~clk;

    typedef struct {
        branchwbInfo_t info;
        bit            killed;
    } mentry_t;

    mentry_t       mq[$];
    bit            m_stall;
    bit            m_mp_vld;
    branchwbInfo_t m_mp_info;
    int            dut_xfer[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    // a strictly older than b: index order, inverted when the wrap bits differ
    function automatic bit older(input robIdx_t a, input robIdx_t b);
        return (a.idx != b.idx) && ((a.idx < b.idx) ^ (a.flip != b.flip));
    endfunction

    function automatic branchwbInfo_t mk(input bit flip, input int idx, input bit mp);
        branchwbInfo_t r;
        r.rob_idx.flip  = flip;
        r.rob_idx.idx   = ROB_IDX_W'(idx);
        r.ftq_idx       = FTQ_IDX_W'($urandom);
        r.has_mispred   = mp;
        r.branch_taken  = 1'($urandom);
        r.target_pc     = $urandom;
        r.branch_npc    = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        i_branchwb_vld  = '0;
        i_branchwbInfo  = '0;
        i_squash_vld    = 1'b0;
        i_squash_robIdx = '0;
    endtask

    // Compare DUT outputs with the model for the current cycle
    task automatic check_outputs();
        bit exp_vld;
        exp_vld = (mq.size() > 0) && !mq[0].killed;
        chk("ftq_vld", 128'(o_ftq_vld), 128'(exp_vld));
        if (exp_vld) chk("ftq_info", 128'(o_ftq_info), 128'(mq[0].info));
        chk("wb_stall", 128'(o_wb_stall), 128'(m_stall));
        chk("mispred_vld", 128'(o_mispred_vld), 128'(m_mp_vld));
        if (m_mp_vld) chk("mispred_info", 128'(o_mispred_info), 128'(m_mp_info));
    endtask

    // Advance the model across the coming rising edge
    task automatic model_update();
        branchwbInfo_t acc[$];
        branchwbInfo_t tmp;
        branchwbInfo_t mp;
        bit            found;
        if (mq.size() > 0) begin
            if (mq[0].killed) void'(mq.pop_front());
            else if (i_ftq_ready) void'(mq.pop_front());
        end
        if (i_squash_vld) begin
            foreach (mq[e]) if (older(i_squash_robIdx, mq[e].info.rob_idx)) mq[e].killed = 1'b1;
        end
        if (!m_stall) begin
            for (int i = 0; i < NUM_IN; i++) if (i_branchwb_vld[i]) acc.push_back(i_branchwbInfo[i]);
        end
        for (int a = 1; a < acc.size(); a++) begin
            for (int b = a; b > 0 && older(acc[b].rob_idx, acc[b-1].rob_idx); b--) begin
                tmp = acc[b]; acc[b] = acc[b-1]; acc[b-1] = tmp;
            end
        end
        found = 1'b0;
        mp    = '0;
        foreach (acc[k]) begin
            mentry_t me;
            me.info   = acc[k];
            me.killed = i_squash_vld && older(i_squash_robIdx, acc[k].rob_idx);
            mq.push_back(me);
            if (!found && acc[k].has_mispred) begin
                found = 1'b1;
                mp    = acc[k];
            end
        end
        m_mp_vld = found && !(i_squash_vld && older(i_squash_robIdx, mp.rob_idx));
        if (found) m_mp_info = mp;
        m_stall = (DEPTH - mq.size()) < NUM_IN;
    endtask

    // One clock: log DUT transfers, compare, update model, move to next falling edge
    task automatic step();
        if (o_ftq_vld && i_ftq_ready) dut_xfer.push_back(int'(o_ftq_info.rob_idx));
        check_outputs();
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        mq.delete();
        m_stall  = 1'b0;
        m_mp_vld = 1'b0;
        chk("rst_ftq_vld", 128'(o_ftq_vld), 128'(0));
        chk("rst_wb_stall", 128'(o_wb_stall), 128'(0));
        chk("rst_mispred_vld", 128'(o_mispred_vld), 128'(0));
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        i_ftq_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // two sources, younger on src0: FTQ sees rob 3 then rob 5
        i_ftq_ready = 1'b1;
        i_branchwbInfo[0] = mk(0, 5, 0);
        i_branchwbInfo[1] = mk(0, 3, 0);
        i_branchwb_vld = 2'b11;
        step(); clear_inputs();
        chk("t_order_first_vld", 128'(o_ftq_vld), 128'(1));
        chk("t_order_first_rob", 128'(o_ftq_info.rob_idx), 128'(6'h03));
        step();
        chk("t_order_second_rob", 128'(o_ftq_info.rob_idx), 128'(6'h05));
        step();
        chk("t_order_empty", 128'(o_ftq_vld), 128'(0));

        // wrap-older mispredict wins: rob{0,7} over rob{1,2}
        i_branchwbInfo[0] = mk(0, 7, 1);
        i_branchwbInfo[1] = mk(1, 2, 1);
        i_branchwb_vld = 2'b11;
        step(); clear_inputs();
        chk("t_mp_vld", 128'(o_mispred_vld), 128'(1));
        chk("t_mp_rob", 128'(o_mispred_info.rob_idx), 128'(6'h07));
        chk("t_mp_head_rob", 128'(o_ftq_info.rob_idx), 128'(6'h07));
        step();
        chk("t_mp_pulse_end", 128'(o_mispred_vld), 128'(0));
        chk("t_mp_second_rob", 128'(o_ftq_info.rob_idx), 128'(6'h22));
        repeat (2) step();

        // fill with ready low: stall after the queue is full, third wave ignored
        i_ftq_ready = 1'b0;
        i_branchwbInfo[0] = mk(0, 10, 0); i_branchwbInfo[1] = mk(0, 11, 0); i_branchwb_vld = 2'b11;
        step();
        chk("t_full_stall_w1", 128'(o_wb_stall), 128'(0));
        i_branchwbInfo[0] = mk(0, 12, 0); i_branchwbInfo[1] = mk(0, 13, 0);
        step();
        chk("t_full_stall_w2", 128'(o_wb_stall), 128'(1));
        i_branchwbInfo[0] = mk(0, 14, 0); i_branchwbInfo[1] = mk(0, 15, 0);
        step(); clear_inputs();
        chk("t_full_stall_w3", 128'(o_wb_stall), 128'(1));
        i_ftq_ready = 1'b1;
        dut_xfer.delete();
        repeat (6) step();
        chk("t_full_count", 128'(dut_xfer.size()), 128'(4));
        if (dut_xfer.size() == 4) chk("t_full_last", 128'(dut_xfer[3]), 128'(13));

        // squash at rob 4 with 2,4,6 queued: 6 is dropped silently
        i_ftq_ready = 1'b0;
        i_branchwbInfo[0] = mk(0, 2, 0); i_branchwbInfo[1] = mk(0, 4, 0); i_branchwb_vld = 2'b11;
        step(); clear_inputs();
        i_branchwbInfo[0] = mk(0, 6, 0); i_branchwb_vld = 2'b01;
        step(); clear_inputs();
        i_squash_vld = 1'b1; i_squash_robIdx = 6'h04;
        step(); clear_inputs();
        i_ftq_ready = 1'b1;
        dut_xfer.delete();
        repeat (5) step();
        chk("t_squash_count", 128'(dut_xfer.size()), 128'(2));
        if (dut_xfer.size() == 2) begin
            chk("t_squash_first", 128'(dut_xfer[0]), 128'(2));
            chk("t_squash_second", 128'(dut_xfer[1]), 128'(4));
        end

        // reset with three entries queued and a redirect pending
        i_ftq_ready = 1'b0;
        i_branchwbInfo[0] = mk(0, 20, 0); i_branchwbInfo[1] = mk(0, 21, 0); i_branchwb_vld = 2'b11;
        step(); clear_inputs();
        i_branchwbInfo[0] = mk(0, 22, 1); i_branchwb_vld = 2'b01;
        step(); clear_inputs();
        chk("t_rst_pre_stall", 128'(o_wb_stall), 128'(1));
        chk("t_rst_pre_mp", 128'(o_mispred_vld), 128'(1));
        do_reset();
        i_ftq_ready = 1'b1;
        i_branchwbInfo[0] = mk(0, 1, 0); i_branchwb_vld = 2'b01;
        step(); clear_inputs();
        chk("t_rst_post_vld", 128'(o_ftq_vld), 128'(1));
        chk("t_rst_post_rob", 128'(o_ftq_info.rob_idx), 128'(6'h01));
        step();
        chk("t_rst_post_alone", 128'(o_ftq_vld), 128'(0));

        // mispredict squashed in the same cycle: no pulse, entry killed
        i_branchwbInfo[0] = mk(0, 9, 1); i_branchwb_vld = 2'b01;
        i_squash_vld = 1'b1; i_squash_robIdx = 6'h08;
        step(); clear_inputs();
        chk("t_mpsq_vld", 128'(o_mispred_vld), 128'(0));
        chk("t_mpsq_ftq", 128'(o_ftq_vld), 128'(0));
        repeat (2) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            i_ftq_ready    = ($urandom_range(0, 9) < 7);
            i_branchwb_vld = 2'($urandom);
            i_branchwbInfo[0] = mk(1'($urandom), $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0));
            i_branchwbInfo[1] = mk(1'($urandom), $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0));
            while (i_branchwbInfo[1].rob_idx == i_branchwbInfo[0].rob_idx)
                i_branchwbInfo[1] = mk(1'($urandom), $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0));
            i_squash_vld    = ($urandom_range(0, 9) == 0);
            i_squash_robIdx = 6'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
